// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared direction and move-command FSM encodings
package game_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        WAIT_REL = 2'b00,
        IDLE     = 2'b01,
        PEND     = 2'b10,
        HELD     = 2'b11
    } move_state_t;

    // Level of the button that corresponds to direction d; btn is {u,d,l,r}.
    function automatic logic btn_of(input dir_t d, input logic [3:0] btn);
        logic hi;
        case (d)
            DIR_UP:   hi = btn[3];
            DIR_DOWN: hi = btn[2];
            DIR_LEFT: hi = btn[1];
            default:  hi = btn[0];
        endcase
        return hi;
    endfunction

endpackage

// File: rtl/dir_prio_enc.sv
// rtl/dir_prio_enc.sv - fixed-priority up>down>left>right encoder for button levels
module dir_prio_enc
    import game_pkg::*;
(
    input  logic [3:0] btn,
    output dir_t       dir,
    output logic       any
);

    always_comb begin
        any = |btn;
        dir = DIR_UP;
        if (btn[3])      dir = DIR_UP;
        else if (btn[2]) dir = DIR_DOWN;
        else if (btn[1]) dir = DIR_LEFT;
        else if (btn[0]) dir = DIR_RIGHT;
    end

endmodule

// File: rtl/move_cmd_gen.sv
// rtl/move_cmd_gen.sv - one move command per press on a valid/ready handshake; MOVE_AUTO_REPEAT_EN adds hold-to-repeat
module move_cmd_gen
    import game_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000,
    parameter int CNT_W         = $clog2(((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       u,
    input  logic       d,
    input  logic       l,
    input  logic       r,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir
);

    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("move_cmd_gen: repeat timing parameters must be positive");
    end

    move_state_t state, state_nxt;
    dir_t        dir_q, dir_nxt;
    dir_t        enc_dir;
    logic        any_btn;
    logic        latched_hi;
    logic        repeat_hit;
    logic [3:0]  btn;

    assign btn = {u, d, l, r};

    dir_prio_enc u_enc (
        .btn (btn),
        .dir (enc_dir),
        .any (any_btn)
    );

    assign latched_hi = btn_of(dir_q, btn);

`ifdef MOVE_AUTO_REPEAT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;

    // First repeat waits the long hold time, later ones the shorter period.
    assign repeat_hit = first_q ? (cnt_q == CNT_W'(HOLD_CYCLES - 1))
                                : (cnt_q == CNT_W'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            if (state == HELD && state_nxt == HELD)
                cnt_q <= cnt_q + CNT_W'(1);
            else
                cnt_q <= '0;
            if (state == IDLE && state_nxt == PEND)
                first_q <= 1'b1;
            else if (state == HELD && state_nxt == PEND)
                first_q <= 1'b0;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WAIT_REL;
            dir_q <= DIR_UP;
        end else begin
            state <= state_nxt;
            dir_q <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        case (state)
            WAIT_REL: if (!any_btn) state_nxt = IDLE;
            IDLE: begin
                if (any_btn) begin
                    state_nxt = PEND;
                    dir_nxt   = enc_dir;
                end
            end
            PEND: if (move_ready) state_nxt = HELD;
            HELD: begin
                // Switching buttons mid-hold must not fire; require a full release.
                if (!any_btn)         state_nxt = IDLE;
                else if (!latched_hi) state_nxt = WAIT_REL;
                else if (repeat_hit)  state_nxt = PEND;
            end
            default: state_nxt = WAIT_REL;
        endcase
    end

    assign move_valid = (state == PEND);
    assign move_dir   = dir_q;

endmodule

// File: tb/tb_move_cmd_gen.sv
// tb/tb_move_cmd_gen.sv - scoreboard bench for move_cmd_gen (expects repeats when MOVE_AUTO_REPEAT_EN is defined)
module tb_move_cmd_gen;

    typedef struct {
        logic [1:0] dir;
        int         len;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       u = 1'b0, d = 1'b0, l = 1'b0, r = 1'b0;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [1:0] move_dir;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   vlen = 0;
    logic [1:0] vdir = 2'b00;
    exp_t sb[$];

    move_cmd_gen #(
        .HOLD_CYCLES   (10),
        .REPEAT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .u          (u),
        .d          (d),
        .l          (l),
        .r          (r),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_dir   (move_dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_cmd(input logic [1:0] dir, input int len, input int gap);
        exp_t e;
        e.dir = dir;
        e.len = len;
        e.gap = gap;
        sb.push_back(e);
    endtask

    // Monitor: every accepted command must match the head of the scoreboard.
    always @(negedge clk) begin
        if (move_valid === 1'b1) begin
            if (vlen == 0) vdir = move_dir;
            else chk("dir_stable", 32'(move_dir), 32'(vdir));
            vlen++;
            if (move_ready === 1'b1) begin
                chk("cmd_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("cmd_dir", 32'(move_dir), 32'(e.dir));
                    chk("cmd_valid_len", 32'(vlen), 32'(e.len));
                    if (e.gap != 0) chk("cmd_gap", 32'(cyc - last_acc), 32'(e.gap));
                end
                last_acc = cyc;
                vlen = 0;
            end
        end else begin
            vlen = 0;
        end
    end

    initial begin
        // Button held through reset must never fire.
        u = 1'b1;
        move_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        chk("reset_valid", 32'(move_valid), 32'd0);
        chk("reset_dir", 32'(move_dir), 32'd0);
        tick(5);
        u = 1'b0;
        tick(3);
        expect_cmd(2'b10, 1, 0);
        l = 1'b1;
        tick(3);
        l = 1'b0;
        tick(3);

        // Simultaneous up+right with a 5-cycle stall.
        move_ready = 1'b0;
        expect_cmd(2'b00, 6, 0);
        u = 1'b1;
        r = 1'b1;
        tick(1);
        tick(5);
        move_ready = 1'b1;
        tick(1);
        u = 1'b0;
        r = 1'b0;
        tick(3);

        // Press and release inside PEND.
        move_ready = 1'b0;
        expect_cmd(2'b01, 3, 0);
        d = 1'b1;
        tick(1);
        d = 1'b0;
        tick(2);
        move_ready = 1'b1;
        tick(5);

        // Switching buttons while held requires full release.
        expect_cmd(2'b11, 1, 0);
        r = 1'b1;
        tick(3);
        u = 1'b1;
        tick(3);
        r = 1'b0;
        tick(3);
        u = 1'b0;
        tick(2);
        expect_cmd(2'b00, 1, 0);
        u = 1'b1;
        tick(2);
        u = 1'b0;
        tick(3);

        // Long hold of left.
        expect_cmd(2'b10, 1, 0);
`ifdef MOVE_AUTO_REPEAT_EN
        expect_cmd(2'b10, 1, 11);
        for (int i = 0; i < 5; i++) expect_cmd(2'b10, 1, 5);
`endif
        l = 1'b1;
        tick(40);
        l = 1'b0;
        tick(3);

        // Reset mid-handshake discards the pending command.
        move_ready = 1'b0;
        d = 1'b1;
        tick(1);
        chk("pend_valid", 32'(move_valid), 32'd1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("reset_drops_valid", 32'(move_valid), 32'd0);
        move_ready = 1'b1;
        tick(5);
        chk("held_after_reset", 32'(move_valid), 32'd0);
        d = 1'b0;
        tick(2);
        expect_cmd(2'b01, 1, 0);
        d = 1'b1;
        tick(2);
        d = 1'b0;
        tick(4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
